// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared instruction word layout, format codes and FSM states
package instr_encoder_pkg;

   localparam int WORD_W = 32;

   // format codes
   localparam logic FMT_0 = 1'b0;
   localparam logic FMT_1 = 1'b1;

   // field widths
   localparam int OP_W     = 5;
   localparam int SRC_W    = 5;   // {reg flag, 4-bit index}
   localparam int DEST_W   = 4;
   localparam int SHIFT_W  = 5;
   localparam int RES_W    = 8;
   localparam int F1_PAD_W = 3;

   // fields common to both formats
   localparam int OP_LSB       = 0;
   localparam int FMT_BIT      = 5;
   localparam int SRC_A_LSB    = 6;
   localparam int SRC_B_LSB    = 11;
   localparam int NO_SHIFT_BIT = 31;

   // format 0 fields
   localparam int F0_SRC_C_LSB = 16;
   localparam int F0_DEST_LSB  = 21;
   localparam int F0_SHIFT_LSB = 25;
   localparam int F0_NSAT_BIT  = 30;

   // format 1 fields
   localparam int F1_DEST_LSB  = 16;
   localparam int F1_RES_LSB   = 20;
   localparam int F1_PAD_LSB   = 28;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOAD = 1'b1
   } enc_state_t;

   // format 1 has no room for a saturate flag, so it must always saturate
   function automatic logic is_illegal(input logic format, input logic saturate);
      return (format == FMT_1) && !saturate;
   endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational packing of instruction fields into one word
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [4:0]        operation,
   input  logic              format,
   input  logic [3:0]        src_a,
   input  logic [3:0]        src_b,
   input  logic [3:0]        src_c,
   input  logic [3:0]        dest,
   input  logic              src_a_reg,
   input  logic              src_b_reg,
   input  logic              src_c_reg,
   input  logic              saturate,
   input  logic [4:0]        instr_shift,
   input  logic              no_shift,
   input  logic [7:0]        res_addr,
   output logic [WORD_W-1:0] word
);

   // place each field at its package-defined position; format selects the upper half layout
   always_comb begin
      word = '0;
      word[OP_LSB +: OP_W]       = operation;
      word[FMT_BIT]              = format;
      word[SRC_A_LSB +: SRC_W]   = {src_a_reg, src_a};
      word[SRC_B_LSB +: SRC_W]   = {src_b_reg, src_b};
      word[NO_SHIFT_BIT]         = no_shift;
      if (format == FMT_0) begin
         word[F0_SRC_C_LSB +: SRC_W]   = {src_c_reg, src_c};
         word[F0_DEST_LSB +: DEST_W]   = dest;
         word[F0_SHIFT_LSB +: SHIFT_W] = instr_shift;
         word[F0_NSAT_BIT]             = ~saturate;
      end else begin
         word[F1_DEST_LSB +: DEST_W]   = dest;
         word[F1_RES_LSB +: RES_W]     = res_addr;
         word[F1_PAD_LSB +: F1_PAD_W]  = '0;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streams encoded instruction words into the block instruction memory
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   count,
   input  logic                  abort,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4:0]            operation,
   input  logic                  format,
   input  logic [3:0]            src_a,
   input  logic [3:0]            src_b,
   input  logic [3:0]            src_c,
   input  logic [3:0]            dest,
   input  logic                  src_a_reg,
   input  logic                  src_b_reg,
   input  logic                  src_c_reg,
   input  logic                  saturate,
   input  logic [4:0]            instr_shift,
   input  logic                  no_shift,
   input  logic [7:0]            res_addr,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [WORD_W-1:0]     wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   err_index
);

   enc_state_t            state;
   logic [ADDR_WIDTH:0]   remaining;   // words still to be accepted
   logic [ADDR_WIDTH:0]   wr_idx;      // index of the next word to be written
   logic [ADDR_WIDTH-1:0] base_q;
   logic [WORD_W-1:0]     packed_word;
   logic                  xfer;
   logic                  illegal;

   instr_pack u_pack (
      .operation   (operation),
      .format      (format),
      .src_a       (src_a),
      .src_b       (src_b),
      .src_c       (src_c),
      .dest        (dest),
      .src_a_reg   (src_a_reg),
      .src_b_reg   (src_b_reg),
      .src_c_reg   (src_c_reg),
      .saturate    (saturate),
      .instr_shift (instr_shift),
      .no_shift    (no_shift),
      .res_addr    (res_addr),
      .word        (packed_word)
   );

   assign in_ready = (state == ST_LOAD) && (remaining != '0);
   assign busy     = (state == ST_LOAD);
   assign xfer     = in_valid && in_ready;
   assign illegal  = is_illegal(format, saturate);

   // load FSM: accept a start, write one word per legal transfer, finish or abort
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         remaining <= '0;
         wr_idx    <= '0;
         base_q    <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_index <= '0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  error     <= 1'b0;
                  err_index <= '0;
                  base_q    <= base_addr;
                  wr_idx    <= '0;
                  remaining <= count;
                  if (count == '0) begin
                     done <= 1'b1;
                  end else begin
                     state <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  state     <= ST_IDLE;
                  remaining <= '0;
               end else if (remaining == '0) begin
                  // last word is on the write port this cycle
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end else if (xfer) begin
                  if (illegal) begin
                     if (!error) begin
                        error     <= 1'b1;
                        err_index <= wr_idx;
                     end
                  end else begin
                     wr_en     <= 1'b1;
                     wr_addr   <= base_q + wr_idx[ADDR_WIDTH-1:0];
                     wr_data   <= packed_word;
                     wr_idx    <= wr_idx + 1'b1;
                     remaining <= remaining - 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, instruction-memory address width.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, single-cycle load request.
REQ-005 SHALL have port base_addr, input, ADDR_WIDTH, first write address, sampled on accepted start.
REQ-006 SHALL have port count, input, ADDR_WIDTH+1, number of words to load, sampled on accepted start.
REQ-007 SHALL have port abort, input, 1, cancels the load in progress.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1), field handshake.
REQ-009 SHALL have field inputs: operation 5, format 1, src_a/src_b/src_c/dest 4 each, src_a_reg/src_b_reg/src_c_reg 1 each, saturate 1, instr_shift 5, no_shift 1, res_addr 8.
REQ-010 SHALL have outputs wr_en 1, wr_addr ADDR_WIDTH, wr_data 32, to the block instruction memory.
REQ-011 SHALL have outputs busy 1, done 1 (pulse), error 1 (sticky), err_index ADDR_WIDTH+1.

Function
REQ-012 SHALL use states IDLE and LOAD; IDLE->LOAD on start when idle; LOAD->IDLE after the last write, or on abort.
REQ-013 SHALL assert in_ready only in LOAD while remaining accepted count > 0; a transfer is in_valid && in_ready.
REQ-014 Common encoding: bits[4:0]=operation, [5]=format, [10:6]={src_a_reg,src_a}, [15:11]={src_b_reg,src_b}, [31]=no_shift.
REQ-015 Format 0 encoding: [20:16]={src_c_reg,src_c}, [24:21]=dest, [29:25]=instr_shift, [30]=~saturate.
REQ-016 Format 1 encoding: [19:16]=dest, [27:20]=res_addr, [30:28]=0; src_c, src_c_reg and instr_shift are ignored.
REQ-017 A format-1 transfer with saturate=0 is illegal: it is dropped without a write and does not consume count.
REQ-018 On an illegal transfer, SHALL set error and latch err_index as the 0-based index of the next word to be written; the first error wins until the next start.
REQ-019 Latency: a transfer in cycle N SHALL produce wr_en=1 with wr_addr/wr_data in cycle N+1, one write per cycle at full throughput.
REQ-020 wr_addr SHALL be base_addr plus write index, modulo 2^ADDR_WIDTH (wraps silently).
REQ-021 done SHALL pulse one cycle, in the cycle after the final write; busy SHALL be high from the cycle after start until done.
REQ-022 start with count=0 SHALL produce done in the next cycle with no writes.
REQ-023 start while busy SHALL be ignored.
REQ-024 abort SHALL return the block to IDLE in the next cycle; a write registered in that same cycle is suppressed; done does not pulse.
REQ-025 If abort and a transfer coincide, abort wins and the transfer is discarded.
REQ-026 start SHALL clear error and err_index.

Reset
REQ-027 On reset_n low, SHALL enter IDLE with in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, err_index=0.
REQ-028 Reset asserted mid-load SHALL discard the load; after release the block waits for a new start.

Structure
REQ-029 The instruction bit-field positions, format codes, and 32-bit word width SHALL be constants in the shared block package, common with the decoder.
REQ-030 The pure field-to-word packing SHALL be one combinational sub-module, instr_pack; the handshake, counters and FSM live in instr_encoder.

Verification
REQ-031 Format 0 word: op=03, a=2/reg1, b=7/reg0, c=1/reg1, dest=9, shift=4, sat=1, no_shift=0, start base=0x10 count=1 -> wr_addr=0x10, wr_data=32'h09313C83, done next cycle.
REQ-032 Format 1 word: op=10, a=1/reg0, b=0, dest=3, res_addr=A5, sat=1, no_shift=1 -> wr_data=32'h8A530070.
REQ-033 Wrap: base=0xFE, count=4, in_valid held high -> addresses FE, FF, 00, 01 on consecutive cycles, then done.
REQ-034 Illegal: count=3 with an illegal second transfer (format1, sat=0) -> error=1, err_index=1, three words written, done asserted.
REQ-035 Abort after two of five writes, coinciding with a transfer -> no third write, busy low, no done; a new start with count=0 -> done next cycle.
REQ-036 Deassert reset_n mid-load -> all outputs zero immediately; after release, in_ready stays 0 until start.
